// File: rtl/key_expansion_seq_if.sv
// Handshake and read-port bundle between the AES-128 key scheduler and its consumer.
interface key_expansion_seq_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned RND_W = 4;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] rk_out;
  logic [RND_W-1:0] rk_round;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             done;
  logic [RND_W-1:0] rd_idx;
  logic [KEY_W-1:0] rd_key;
  logic             keys_ready;

  modport slave (
    input  start, key_in, rk_ready, rd_idx,
    output rk_out, rk_round, rk_valid, busy, done, rd_key, keys_ready
  );

  modport master (
    output start, key_in, rk_ready, rd_idx,
    input  rk_out, rk_round, rk_valid, busy, done, rd_key, keys_ready
  );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per accepted handshake, rounds 0..10,
// with an optional 11-entry buffer for random-access reuse of the last expanded key.
module key_expansion_seq #(
  parameter int unsigned STORE_KEYS = 1,
  parameter int unsigned NR         = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_expansion_seq_if.slave   bus
);
  localparam int unsigned KEY_W = 128;
  localparam int unsigned RND_W = 4;
  localparam int unsigned NKEYS = 11;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

  // AES S-box, byte 0x00 at the most significant end
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One key-schedule step: derive round key r+1 from round key r
  function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k,
                                                input logic [7:0]       rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t           state_q, state_d;
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  logic [RND_W-1:0] rk_round_q, rk_round_d;
  logic             rk_valid_q, rk_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             keys_ready_q, keys_ready_d;
  logic             hs_c;
  logic [KEY_W-1:0] next_key_c;

  assign hs_c       = rk_valid_q & bus.rk_ready;
  assign next_key_c = next_key(rk_out_q, rcon(RND_W'(rk_round_q + 4'd1)));

  always_comb begin
    state_d      = state_q;
    rk_out_d     = rk_out_q;
    rk_round_d   = rk_round_q;
    rk_valid_d   = rk_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    keys_ready_d = keys_ready_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rk_out_d     = bus.key_in;
          rk_round_d   = '0;
          rk_valid_d   = 1'b1;
          busy_d       = 1'b1;
          keys_ready_d = 1'b0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (hs_c) begin
          if (rk_round_q == LAST_RND) begin
            rk_valid_d   = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            keys_ready_d = (STORE_KEYS != 0);
            state_d      = IDLE;
          end else begin
            rk_out_d   = next_key_c;
            rk_round_d = RND_W'(rk_round_q + 4'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rk_out_q     <= '0;
      rk_round_q   <= '0;
      rk_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rk_out_q     <= rk_out_d;
      rk_round_q   <= rk_round_d;
      rk_valid_q   <= rk_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_ready_q <= keys_ready_d;
    end
  end

  assign bus.rk_out     = rk_out_q;
  assign bus.rk_round   = rk_round_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.keys_ready = keys_ready_q;

  // Round-key buffer is intentionally not reset; keys_ready qualifies its contents
  if (STORE_KEYS != 0) begin : g_buf
    logic [KEY_W-1:0] buf_q [NKEYS];

    always_ff @(posedge clk) begin
      if (hs_c && (rk_round_q <= LAST_RND)) begin
        buf_q[rk_round_q] <= rk_out_q;
      end
    end

    assign bus.rd_key = (bus.rd_idx <= LAST_RND) ? buf_q[bus.rd_idx] : '0;
  end else begin : g_nobuf
    assign bus.rd_key = '0;
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed scoreboard bench for key_expansion_seq using FIPS-197 and all-zero key vectors.
module tb_key_expansion_seq;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_expansion_seq_if ifc ();

  key_expansion_seq #(.STORE_KEYS(1), .NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  localparam logic [127:0] K1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] Z1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         chk;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   nvalid;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected sequence for one expansion; the zero key is only known for rounds 0..2
  task automatic push_expansion(input bit zero_key);
    for (int r = 0; r < 11; r++) begin
      if (zero_key)
        sb.push_back('{4'(r), (r == 1) ? Z1 : (r == 2) ? Z2 : 128'h0, r <= 2});
      else
        sb.push_back('{4'(r), K1[r], 1'b1});
    end
  endtask

  // Advance one cycle, scoring any handshake that the coming edge will perform
  task automatic step();
    exp_t e;
    if (ifc.rk_valid === 1'b1 && ifc.rk_ready === 1'b1) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow observed_round=%0d expected=queued_entry", ifc.rk_round);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rk_round", 128'(ifc.rk_round), 128'(e.rnd));
        if (e.chk) check("rk_out", ifc.rk_out, e.key);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_key(input logic [127:0] k, input bit zero_key);
    ifc.key_in = k;
    ifc.start  = 1'b1;
    push_expansion(zero_key);
    step();
    ifc.start  = 1'b0;
    ifc.key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int budget, output int nv);
    nv = 0;
    for (int i = 0; i < budget; i++) begin
      if (ifc.done === 1'b1) break;
      if (ifc.rk_valid === 1'b1) nv++;
      step();
    end
    check("done_reached", 128'(ifc.done), 128'(1));
  endtask

  task automatic run_to(input int r);
    for (int i = 0; i < 30; i++) begin
      if (ifc.rk_valid === 1'b1 && ifc.rk_round == 4'(r)) break;
      step();
    end
    check("round_reached", 128'(ifc.rk_round), 128'(r));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rk_out"},     ifc.rk_out,              128'h0);
    check({tag, "_rk_round"},   128'(ifc.rk_round),      128'h0);
    check({tag, "_rk_valid"},   128'(ifc.rk_valid),      128'h0);
    check({tag, "_busy"},       128'(ifc.busy),          128'h0);
    check({tag, "_done"},       128'(ifc.done),          128'h0);
    check({tag, "_keys_ready"}, 128'(ifc.keys_ready),    128'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    ifc.start    = 1'b0;
    ifc.key_in   = '0;
    ifc.rk_ready = 1'b0;
    ifc.rd_idx   = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: FIPS-197 key, consumer always ready
    ifc.rk_ready = 1'b1;
    start_key(K1[0], 1'b0);
    check("t1_busy", 128'(ifc.busy), 128'(1));
    wait_done(40, nvalid);
    check("t1_valid_cycles", 128'(nvalid), 128'(11));
    check("t1_busy_after", 128'(ifc.busy), 128'(0));
    check("t1_valid_after", 128'(ifc.rk_valid), 128'(0));
    check("t1_keys_ready", 128'(ifc.keys_ready), 128'(1));
    check("t1_sb_empty", 128'(sb.size()), 128'(0));
    step();
    check("t1_done_pulse", 128'(ifc.done), 128'(0));

    // T6: random-access readback of the stored schedule
    for (int i = 0; i < 11; i++) begin
      ifc.rd_idx = 4'(i);
      #1;
      check("t6_rd_key", ifc.rd_key, K1[i]);
    end
    ifc.rd_idx = 4'd12;
    #1;
    check("t6_rd_key_oob12", ifc.rd_key, 128'h0);
    ifc.rd_idx = 4'd11;
    #1;
    check("t6_rd_key_oob11", ifc.rd_key, 128'h0);
    check("t6_keys_ready", 128'(ifc.keys_ready), 128'(1));
    @(negedge clk);

    // T2: all-zero key; new start clears keys_ready
    start_key(128'h0, 1'b1);
    check("t2_keys_ready_clr", 128'(ifc.keys_ready), 128'(0));
    wait_done(40, nvalid);
    check("t2_valid_cycles", 128'(nvalid), 128'(11));
    step();

    // T3: five-cycle stall at round 3
    start_key(K1[0], 1'b0);
    run_to(3);
    ifc.rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stall_round", 128'(ifc.rk_round), 128'(3));
      check("t3_stall_key", ifc.rk_out, K1[3]);
      check("t3_stall_valid", 128'(ifc.rk_valid), 128'(1));
    end
    ifc.rk_ready = 1'b1;
    wait_done(40, nvalid);

    // T4: start in the done cycle is accepted; start while busy is ignored
    start_key(K1[0], 1'b0);
    check("t4_accept_in_done_cycle", 128'(ifc.rk_valid), 128'(1));
    run_to(5);
    ifc.key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    ifc.start  = 1'b1;
    step();
    ifc.start  = 1'b0;
    wait_done(40, nvalid);
    check("t4_sb_empty", 128'(sb.size()), 128'(0));
    step();

    // T5: asynchronous reset mid-expansion, then a clean restart
    start_key(K1[0], 1'b0);
    run_to(6);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_key(K1[0], 1'b0);
    wait_done(40, nvalid);
    check("t5_valid_cycles", 128'(nvalid), 128'(11));
    check("t5_keys_ready", 128'(ifc.keys_ready), 128'(1));
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
